// File: rtl/grid_write_ctrl.sv
// grid_write_ctrl: owns the grid cell-state vector, serialises user/system writes
// with round-robin arbitration, and runs a cell-by-cell clear sweep that pre-empts both.
module grid_write_ctrl #(
  parameter int SIZE_X      = 10,
  parameter int SIZE_Y      = 10,
  parameter int CELL_BITS   = 1,
  parameter int CLEAR_VALUE = 0,
  parameter int XBITS       = $clog2(SIZE_X),
  parameter int YBITS       = $clog2(SIZE_Y),
  parameter int GDBITS      = CELL_BITS * SIZE_X * SIZE_Y
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  output logic                 clear_busy,
  input  logic                 usr_valid,
  output logic                 usr_ready,
  input  logic [XBITS-1:0]     usr_x,
  input  logic [YBITS-1:0]     usr_y,
  input  logic [CELL_BITS-1:0] usr_type,
  input  logic                 sys_valid,
  output logic                 sys_ready,
  input  logic [XBITS-1:0]     sys_x,
  input  logic [YBITS-1:0]     sys_y,
  input  logic [CELL_BITS-1:0] sys_type,
  output logic [GDBITS-1:0]    data,
  output logic                 wr_ack,
  output logic                 wr_err
);

  localparam int NCELLS = SIZE_X * SIZE_Y;
  localparam int CBITS  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam int IBITS  = (GDBITS > 1) ? $clog2(GDBITS) : 1;
  localparam logic [CELL_BITS-1:0] CLEAR_CELL = CELL_BITS'(CLEAR_VALUE);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {GRANT_USR, GRANT_SYS} grant_t;

  state_t               state;
  state_t               state_next;
  grant_t               last_grant;
  logic [CBITS-1:0]     count;
  logic                 usr_grant;
  logic                 sys_grant;
  logic                 accept_open;
  logic                 xfer;
  logic                 sel_in_range;
  logic                 last_cell;
  logic [XBITS-1:0]     sel_x;
  logic [YBITS-1:0]     sel_y;
  logic [CELL_BITS-1:0] sel_type;
  logic [IBITS-1:0]     wr_index;
  logic [IBITS-1:0]     clr_index;

  // On a tie the port that did not win the previous transfer goes first.
  always_comb begin
    usr_grant    = usr_valid & (~sys_valid | (last_grant == GRANT_SYS));
    sys_grant    = sys_valid & (~usr_valid | (last_grant == GRANT_USR));
    accept_open  = (state == IDLE) & ~clear_req & ~rst;
    usr_ready    = accept_open & usr_grant;
    sys_ready    = accept_open & sys_grant;
    xfer         = usr_ready | sys_ready;
    sel_x        = usr_ready ? usr_x : sys_x;
    sel_y        = usr_ready ? usr_y : sys_y;
    sel_type     = usr_ready ? usr_type : sys_type;
    sel_in_range = (int'(sel_x) < SIZE_X) && (int'(sel_y) < SIZE_Y);
    wr_index     = IBITS'((int'(sel_y) * SIZE_X + int'(sel_x)) * CELL_BITS);
    clr_index    = IBITS'(int'(count) * CELL_BITS);
    last_cell    = (int'(count) == NCELLS - 1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_req) state_next = CLEAR;
      CLEAR:   if (last_cell) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign clear_busy = (state == CLEAR);

  // Reset zeroes the grid outright, even mid-sweep and whatever CLEAR_VALUE is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= GRANT_SYS;
      data       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      state  <= state_next;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (state == CLEAR) begin
        data[clr_index +: CELL_BITS] <= CLEAR_CELL;
        count <= last_cell ? '0 : count + 1'b1;
      end else if (xfer) begin
        last_grant <= usr_ready ? GRANT_USR : GRANT_SYS;
        if (sel_in_range) begin
          data[wr_index +: CELL_BITS] <= sel_type;
          wr_ack <= 1'b1;
        end else begin
          wr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/grid_write_ctrl.md
# grid_write_ctrl

Owns the flattened cell-state vector consumed by `grid` (`data`, row-major, CELL_BITS per cell) and serialises every modification to it. It arbitrates two write requesters and runs a cell-by-cell clear sweep that has priority over both. The requesters are the user port (mouse/click path, fed from `grid` cell_pos_x/y) and the system port (game logic).

## Interface
- SIZE_X, 8'd10, grid width in cells
- SIZE_Y, 8'd10, grid height in cells
- CELL_BITS, 4'd1, bits per cell
- CLEAR_VALUE, 0, cell value written by the clear sweep (CELL_BITS wide)
- XBITS, $clog2(SIZE_X), column index width
- YBITS, $clog2(SIZE_Y), row index width
- GDBITS, CELL_BITS*SIZE_X*SIZE_Y, width of the data vector
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- clear_req  in  1  single-cycle request to start a clear sweep
- clear_busy  out  1  high while the sweep runs
- usr_valid  in  1  user write request
- usr_ready  out  1  user request accepted this cycle
- usr_x / usr_y  in  XBITS / YBITS  user target cell
- usr_type  in  CELL_BITS  value to write
- sys_valid, sys_ready, sys_x, sys_y, sys_type  same widths and roles as the user port
- data  out  GDBITS  registered cell-state vector to `grid`
- wr_ack  out  1  one-cycle pulse after an in-range write is committed
- wr_err  out  1  one-cycle pulse after an out-of-range request is accepted

## Operation
- FSM states: IDLE and CLEAR. Reset puts the FSM in IDLE.
- Cell index is (y*SIZE_X + x)*CELL_BITS. A write updates data[index +: CELL_BITS] only. All other bits hold.
- A request is in range when x < SIZE_X and y < SIZE_Y. The `grid` sentinel (x==SIZE_X or y==SIZE_Y) is out of range.
- Handshake: a transfer happens when valid&ready is high at a rising edge.
  - ready is combinational: state==IDLE & ~clear_req & granted.
  - A requester holds x/y/type stable while valid is high and not yet accepted.
- Arbitration is round-robin.
  - One requester valid: it is granted.
  - Both valid: the port not granted last is granted.
  - last_grant updates only on a completed transfer. Its reset value is sys, so the user port wins the first tie.
  - At most one transfer per cycle.
- In-range transfer: data is written at the transfer edge. wr_ack is high the following cycle.
- Out-of-range transfer: the request is consumed and data is unchanged. wr_err is high the following cycle.
- clear_req sampled high in IDLE:
  - The FSM enters CLEAR at that edge. Both readies are low in the request cycle.
  - In CLEAR, an internal counter c runs 0..SIZE_X*SIZE_Y-1. Each cycle cell c gets CLEAR_VALUE.
  - After the last cell the FSM returns to IDLE.
- clear_req while in CLEAR is ignored. The sweep does not restart.
- Both readies stay low throughout CLEAR. Pending valids are held by the requesters and served after CLEAR.
- CLEAR_VALUE is truncated/zero-extended to CELL_BITS.

## Timing
- Reset values: data all zero, clear_busy 0, wr_ack 0, wr_err 0, usr_ready/sys_ready 0 during rst, FSM IDLE, counter 0, last_grant sys.
- rst asserted mid-sweep: the sweep is aborted and data is zeroed on the next edge, regardless of CLEAR_VALUE.
- Write latency: data reflects an accepted write one cycle after the transfer edge. `grid` cell_type follows combinationally.
- Clear latency: clear_req at edge k gives clear_busy high for exactly SIZE_X*SIZE_Y cycles starting after edge k.
  - Cell n is written at edge k+1+n.
  - The first request can be accepted in the cycle after clear_busy falls.
- Throughput: one write per cycle in IDLE. A continuous both-valid stream alternates usr, sys, usr, ...
- wr_ack and wr_err are mutually exclusive and never high for two cycles from a single transfer.

## Test plan
- Reset, then usr_valid=1 at x=3, y=2, type=1 (10x10, CELL_BITS=1) -> usr_ready=1 same cycle. Next cycle data[23]=1, all other bits 0, wr_ack=1.
- usr and sys both valid every cycle, distinct cells, for 4 cycles -> grants usr, sys, usr, sys. 4 wr_ack pulses. 4 bits set.
- sys_valid with x=10 (sentinel), y=0 -> sys_ready=1, data unchanged, wr_err=1 next cycle, wr_ack=0.
- Data all ones, then clear_req pulse with CLEAR_VALUE=0 -> clear_busy high exactly 100 cycles. Cell n is 0 after edge k+1+n. A usr_valid held throughout is accepted the cycle after clear_busy falls.
- clear_req again at sweep cycle 50 -> ignored. clear_busy still falls after 100 cycles total.
- rst asserted at sweep cycle 30, CLEAR_VALUE=1, CELL_BITS=2 -> next cycle data=0, clear_busy=0, FSM IDLE.
